// File: rtl/act_out_writer.sv
// Buffers activation vectors from a non-stallable source and writes them to consecutive output-buffer addresses.
// Latency: a vector pushed at edge t can be written from cycle t+1; there is no input-to-output bypass.
// Backpressure: wr_ready stalls are absorbed by the FIFO; input that cannot be stored is dropped and flagged in overflow.
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 8
`endif
`ifndef Tout
`define Tout 4
`endif

module act_out_writer #(
  parameter int DAT_W  = `MAX_DAT_DW,
  parameter int LANES  = `Tout,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CNT_W-1:0]           num_vec,
  input  logic [DAT_W*LANES-1:0]     dat_in,
  input  logic                       in_vld,
  output logic                       wr_vld,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DAT_W*LANES-1:0]     wr_dat,
  input  logic                       wr_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int VW = DAT_W * LANES;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     mem [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q, rcv_q, wrn_q;
  logic              overflow_q;
  logic              full, empty, push, pop, drop, start_acc, last_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level     = wptr_q - rptr_q;

  assign wr_vld    = (state_q == S_RUN) && !empty;
  assign wr_addr   = base_q + ADDR_W'(wrn_q);
  assign wr_dat    = mem[rptr_q[AW-1:0]];
  assign overflow  = overflow_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop       = wr_vld && wr_ready;
  assign push      = (state_q == S_RUN) && in_vld && (rcv_q < num_q) && (!full || pop);
  assign drop      = in_vld && !push;
  assign start_acc = (state_q == S_IDLE) && start;
  assign last_pop  = pop && ((wrn_q + CNT_W'(1)) == num_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_vec == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_pop) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job registers, counters, FIFO pointers and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      num_q      <= '0;
      rcv_q      <= '0;
      wrn_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q <= base_addr;
        num_q  <= num_vec;
        rcv_q  <= '0;
        wrn_q  <= '0;
      end
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        rcv_q  <= rcv_q + CNT_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        wrn_q  <= wrn_q + CNT_W'(1);
      end
      // A vector dropped in the start cycle itself still counts as lost.
      if (start_acc)  overflow_q <= drop;
      else if (drop)  overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= dat_in;
  end

endmodule

// File: tb/tb_act_out_writer.sv
// Directed bench for act_out_writer with DAT_W=8, LANES=4, DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Every expected value below is hand-derived from the block's behaviour.
module tb_act_out_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_vec;
  logic [31:0] dat_in;
  logic        in_vld;
  logic        wr_vld;
  logic [15:0] wr_addr;
  logic [31:0] wr_dat;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  act_out_writer #(
    .DAT_W(8), .LANES(4), .DEPTH(4), .ADDR_W(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .dat_in(dat_in), .in_vld(in_vld), .wr_vld(wr_vld), .wr_addr(wr_addr),
    .wr_dat(wr_dat), .wr_ready(wr_ready), .busy(busy), .done(done),
    .overflow(overflow), .level(level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0;
    dat_in = '0; in_vld = 1'b0; wr_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    tick();

    // 1: three back-to-back vectors, write port always ready
    start = 1'b1; base_addr = 16'h0100; num_vec = 16'd3; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy", busy, 1);
    chk("s1_no_wr_before_push", wr_vld, 0);
    in_vld = 1'b1; dat_in = 32'h04030201;
    tick();
    chk("s1_w0_vld", wr_vld, 1);
    chk("s1_w0_addr", wr_addr, 16'h0100);
    chk("s1_w0_dat", wr_dat, 32'h04030201);
    dat_in = 32'h08070605;
    tick();
    chk("s1_w1_addr", wr_addr, 16'h0101);
    chk("s1_w1_dat", wr_dat, 32'h08070605);
    chk("s1_w1_level", level, 1);
    dat_in = 32'h0C0B0A09;
    tick();
    chk("s1_w2_addr", wr_addr, 16'h0102);
    chk("s1_w2_dat", wr_dat, 32'h0C0B0A09);
    in_vld = 1'b0;
    tick();
    chk("s1_done", done, 1);
    chk("s1_done_no_wr", wr_vld, 0);
    chk("s1_done_busy", busy, 1);
    tick();
    chk("s1_done_pulse", done, 0);
    chk("s1_idle_busy", busy, 0);
    chk("s1_overflow", overflow, 0);

    // 2: six vectors into a stalled port; two are dropped, job never completes
    start = 1'b1; base_addr = 16'h0200; num_vec = 16'd6; wr_ready = 1'b0;
    tick();
    start = 1'b0;
    in_vld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      dat_in = 32'hA0A00000 + k;
      tick();
    end
    in_vld = 1'b0;
    chk("s2_level_full", level, 4);
    chk("s2_overflow", overflow, 1);
    chk("s2_wr_vld", wr_vld, 1);
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s2_addr", wr_addr, 16'h0200 + k);
      chk("s2_dat", wr_dat, 32'hA0A00001 + k);
      tick();
    end
    chk("s2_empty_vld", wr_vld, 0);
    chk("s2_level_zero", level, 0);
    chk("s2_no_done", done, 0);
    tick();
    chk("s2_still_busy", busy, 1);
    chk("s2_still_no_done", done, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s2_rst_overflow", overflow, 0);

    // 3: push into a full FIFO while the head is written in the same cycle
    start = 1'b1; base_addr = 16'h0300; num_vec = 16'd5; wr_ready = 1'b0;
    tick();
    start = 1'b0;
    in_vld = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      dat_in = 32'hB0B00000 + k;
      tick();
    end
    chk("s3_level_full", level, 4);
    chk("s3_w0_addr", wr_addr, 16'h0300);
    chk("s3_w0_dat", wr_dat, 32'hB0B00001);
    wr_ready = 1'b1; dat_in = 32'hB0B00005;
    tick();
    in_vld = 1'b0;
    chk("s3_level_kept", level, 4);
    chk("s3_overflow", overflow, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("s3_addr", wr_addr, 16'h0300 + k);
      chk("s3_dat", wr_dat, 32'hB0B00001 + k);
      tick();
    end
    chk("s3_done", done, 1);
    tick();

    // 4: zero-length job, then a drop in IDLE and its clear by start
    start = 1'b1; base_addr = 16'h0400; num_vec = 16'd0; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("s4_done", done, 1);
    chk("s4_busy", busy, 1);
    chk("s4_no_wr", wr_vld, 0);
    tick();
    chk("s4_done_gone", done, 0);
    chk("s4_busy_gone", busy, 0);
    in_vld = 1'b1; dat_in = 32'hDEADBEEF;
    tick();
    in_vld = 1'b0;
    chk("s4_idle_drop", overflow, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s4_start_clears", overflow, 0);
    tick();

    // 5: stall holds the request, start in RUN is ignored, reset aborts
    start = 1'b1; base_addr = 16'h0500; num_vec = 16'd4; wr_ready = 1'b0;
    tick();
    start = 1'b0;
    in_vld = 1'b1; dat_in = 32'hC0C00001;
    tick();
    dat_in = 32'hC0C00002;
    tick();
    in_vld = 1'b0;
    chk("s5_w0_addr", wr_addr, 16'h0500);
    wr_ready = 1'b1;
    tick();
    chk("s5_w1_addr", wr_addr, 16'h0501);
    wr_ready = 1'b0;
    tick();
    chk("s5_stall1_vld", wr_vld, 1);
    chk("s5_stall1_addr", wr_addr, 16'h0501);
    chk("s5_stall1_dat", wr_dat, 32'hC0C00002);
    start = 1'b1; base_addr = 16'h0900; num_vec = 16'd1;
    tick();
    start = 1'b0;
    chk("s5_stall2_addr", wr_addr, 16'h0501);
    chk("s5_stall2_dat", wr_dat, 32'hC0C00002);
    wr_ready = 1'b1;
    tick();
    chk("s5_after_pop_vld", wr_vld, 0);
    chk("s5_ignored_start_busy", busy, 1);
    chk("s5_ignored_start_done", done, 0);
    wr_ready = 1'b0; in_vld = 1'b1; dat_in = 32'hC0C00003;
    tick();
    in_vld = 1'b0;
    chk("s5_level_before_rst", level, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_vld", wr_vld, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_done", done, 0);
    chk("s5_rst_level", level, 0);
    chk("s5_rst_addr", wr_addr, 0);
    tick();
    chk("s5_no_done_after_abort", done, 0);

    // 6: address wrap at the top of the address space
    start = 1'b1; base_addr = 16'hFFFE; num_vec = 16'd3; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    in_vld = 1'b1; dat_in = 32'hE0E00001;
    tick();
    chk("s6_addr0", wr_addr, 16'hFFFE);
    dat_in = 32'hE0E00002;
    tick();
    chk("s6_addr1", wr_addr, 16'hFFFF);
    dat_in = 32'hE0E00003;
    tick();
    chk("s6_addr2", wr_addr, 16'h0000);
    chk("s6_dat2", wr_dat, 32'hE0E00003);
    in_vld = 1'b0;
    tick();
    chk("s6_done", done, 1);
    chk("s6_overflow", overflow, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
